icache_refill: RTL and testbench

Refill and flush sequencer for the instruction cache. It accepts a miss from fetch1 and issues one line read on the memory bus. It writes the returned words, critical word first, into the icache CAM through the fe1_cam_write_* path. It also sweeps every CAM index to invalidate the cache on request. It sits between fetch1, the icache CAM write port and the memory read port.

---
 rtl/icache_refill_if.sv | 53 +++++
 rtl/icache_refill.sv | 186 ++++++++++++++++++
 tb/tb_icache_refill.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_if
// Description : Bundle of the refill sequencer's fetch1 handshake, memory
//               read bus and icache CAM write port.
//               master = the refill sequencer, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_refill_if;
    // fetch1 miss / flush handshake
    logic           miss_req;
    logic [28:2]    miss_addr;
    logic           miss_ack;
    logic           miss_err;
    logic           flush_req;
    logic           flush_done;
    logic           busy;

    // memory read bus
    logic           mem_req;
    logic [28:2]    mem_addr;
    logic           mem_gnt;
    logic           mem_rvalid;
    logic [31:0]    mem_rdata;
    logic           mem_rerr;

    // icache CAM write port
    logic [11:2]    cam_write_index;
    logic           cam_write_req_data;
    logic [31:0]    cam_write_data;
    logic           cam_write_req_tag_flags;
    logic [28:12]   cam_write_tag;
    logic [1:0]     cam_write_flags;

    modport master (
        input  miss_req, miss_addr, flush_req,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_rerr,
        output miss_ack, miss_err, flush_done, busy,
        output mem_req, mem_addr,
        output cam_write_index, cam_write_req_data, cam_write_data,
        output cam_write_req_tag_flags, cam_write_tag, cam_write_flags
    );

    modport slave (
        output miss_req, miss_addr, flush_req,
        output mem_gnt, mem_rvalid, mem_rdata, mem_rerr,
        input  miss_ack, miss_err, flush_done, busy,
        input  mem_req, mem_addr,
        input  cam_write_index, cam_write_req_data, cam_write_data,
        input  cam_write_req_tag_flags, cam_write_tag, cam_write_flags
    );
endinterface
`default_nettype wire

// File: rtl/icache_refill.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill
// Description : Instruction cache refill and flush sequencer. Fetches one
//               line per miss (critical word first, wrapping in the line),
//               writes each returned beat into the CAM one cycle later, and
//               sweeps all 1024 CAM indices on a flush request.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill #(
    parameter int LINE_WORDS = 4
) (
    input  logic                clk_core,
    input  logic                reset,
    icache_refill_if.master     bus
);

    localparam int                  c_OFS_W      = $clog2(LINE_WORDS);
    localparam logic [c_OFS_W-1:0]  c_LAST_BEAT  = c_OFS_W'(LINE_WORDS - 1);
    localparam logic [10:0]         c_FLUSH_END  = 11'd1024;
    localparam logic [9:0]          c_IDX_LAST   = 10'd1023;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        FILL  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [28:2]            r_addr;
    logic [c_OFS_W-1:0]     r_beat;
    logic                   r_err;
    logic                   r_flush_pend;
    logic [10:0]            r_fcnt;

    logic                   w_flush_go;
    logic                   w_last_beat;
    logic [c_OFS_W-1:0]     w_wofs;
    logic [9:0]             w_fill_idx;

    // Beat k lands at the critical word's offset plus k, wrapped in the line.
    assign w_wofs      = r_addr[c_OFS_W+1:2] + r_beat;
    assign w_fill_idx  = {r_addr[11:c_OFS_W+2], w_wofs};
    assign w_last_beat = bus.mem_rvalid && (r_beat == c_LAST_BEAT);

    // A sweep starts on the edge that enters FLUSH from IDLE or DONE.
    assign w_flush_go  = (w_next == FLUSH) && (r_state != FLUSH);

    assign bus.busy     = (r_state != IDLE) || r_flush_pend;
    assign bus.mem_req  = (r_state == REQ);
    assign bus.mem_addr = r_addr;

    // State register.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; flushes (new or deferred) win over misses.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_flush_pend || bus.flush_req) begin
                    w_next = FLUSH;
                end else if (bus.miss_req) begin
                    w_next = REQ;
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    w_next = FILL;
                end
            end
            FILL: begin
                if (w_last_beat) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                // A flush deferred during the refill runs straight after it.
                if (r_flush_pend || bus.flush_req) begin
                    w_next = FLUSH;
                end else begin
                    w_next = IDLE;
                end
            end
            FLUSH: begin
                if (r_fcnt == c_FLUSH_END) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Remember a flush request that arrives while busy with something else.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_flush_pend <= 1'b0;
        end else if (w_flush_go) begin
            r_flush_pend <= 1'b0;
        end else if (bus.flush_req && (r_state != IDLE)) begin
            r_flush_pend <= 1'b1;
        end
    end

    // Miss context: address latch, beat counter and error sticky.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_beat <= '0;
            r_err  <= 1'b0;
        end else if ((r_state == IDLE) && (w_next == REQ)) begin
            r_addr <= bus.miss_addr;
            r_beat <= '0;
            r_err  <= 1'b0;
        end else if ((r_state == FILL) && bus.mem_rvalid) begin
            r_beat <= r_beat + 1'b1;
            r_err  <= r_err | bus.mem_rerr;
        end
    end

    // Sweep counter: index 0 is written on entry, so counting resumes at 1.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_fcnt <= '0;
        end else if (w_flush_go) begin
            r_fcnt <= 11'd1;
        end else if ((r_state == FLUSH) && (r_fcnt != c_FLUSH_END)) begin
            r_fcnt <= r_fcnt + 11'd1;
        end
    end

    // Registered CAM write port and completion pulses; idle cycles drive zeros.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            bus.cam_write_index         <= '0;
            bus.cam_write_req_data      <= 1'b0;
            bus.cam_write_data          <= '0;
            bus.cam_write_req_tag_flags <= 1'b0;
            bus.cam_write_tag           <= '0;
            bus.cam_write_flags         <= '0;
            bus.miss_ack                <= 1'b0;
            bus.miss_err                <= 1'b0;
            bus.flush_done              <= 1'b0;
        end else begin
            bus.cam_write_index         <= '0;
            bus.cam_write_req_data      <= 1'b0;
            bus.cam_write_data          <= '0;
            bus.cam_write_req_tag_flags <= 1'b0;
            bus.cam_write_tag           <= '0;
            bus.cam_write_flags         <= '0;
            bus.miss_ack                <= 1'b0;
            bus.miss_err                <= 1'b0;
            bus.flush_done              <= 1'b0;
            if (w_flush_go) begin
                bus.cam_write_req_tag_flags <= 1'b1;
            end else if ((r_state == FILL) && bus.mem_rvalid) begin
                bus.cam_write_index         <= w_fill_idx;
                bus.cam_write_req_data      <= 1'b1;
                bus.cam_write_data          <= bus.mem_rdata;
                bus.cam_write_req_tag_flags <= 1'b1;
                bus.cam_write_tag           <= r_addr[28:12];
                bus.cam_write_flags         <= {bus.mem_rerr, ~bus.mem_rerr};
                if (w_last_beat) begin
                    bus.miss_ack <= 1'b1;
                    bus.miss_err <= r_err | bus.mem_rerr;
                end
            end else if ((r_state == FLUSH) && (r_fcnt != c_FLUSH_END)) begin
                bus.cam_write_index         <= r_fcnt[9:0];
                bus.cam_write_req_tag_flags <= 1'b1;
                bus.flush_done              <= (r_fcnt[9:0] == c_IDX_LAST);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_refill.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_refill
// Description : Directed self-checking bench for icache_refill (LINE_WORDS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill;

    typedef struct {
        int             c;
        logic [9:0]     idx;
        logic [31:0]    d;
        logic [16:0]    tag;
        logic [1:0]     fl;
        logic           rd;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_miss = 0;
    int         n_ack = 0;
    int         ack_cyc = 0;
    logic       ack_err = 1'b0;
    int         n_fd = 0;
    int         fd_cyc = 0;
    string      cur = "reset";
    wr_t        q[$];

    icache_refill_if bus();

    icache_refill #(.LINE_WORDS(4)) dut (
        .clk_core (clk),
        .reset    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every CAM write and completion pulse away from the active edge.
    always @(negedge clk) begin
        wr_t w;
        if (bus.cam_write_req_tag_flags) begin
            w.c   = cyc;
            w.idx = bus.cam_write_index;
            w.d   = bus.cam_write_data;
            w.tag = bus.cam_write_tag;
            w.fl  = bus.cam_write_flags;
            w.rd  = bus.cam_write_req_data;
            q.push_back(w);
        end
        if (bus.miss_ack) begin
            n_ack   <= n_ack + 1;
            ack_cyc <= cyc;
            ack_err <= bus.miss_err;
        end
        if (bus.flush_done) begin
            n_fd   <= n_fd + 1;
            fd_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s/%s: observed %0h expected %0h", cur, tag, obs, exp);
        end
    endtask

    task automatic chk_outs_zero();
        chk("ctrl_zero", {bus.mem_req, bus.miss_ack, bus.miss_err, bus.flush_done, bus.busy,
                          bus.cam_write_req_data, bus.cam_write_req_tag_flags}, 64'd0);
        chk("cam_zero", {bus.cam_write_index, bus.cam_write_data, bus.cam_write_tag,
                         bus.cam_write_flags}, 64'd0);
        chk("mem_addr_zero", bus.mem_addr, 64'd0);
    endtask

    // Drive one refill: grant after gdly stall cycles, gap3 idle cycles before
    // beat 3, error beats per emask, optional flush pulse with beat flush_k.
    task automatic run_miss(input string name, input logic [26:0] a, input int gdly,
                            input int gap3, input logic [3:0] emask, input int flush_k,
                            input bit keep_req);
        int         t;
        int         bcyc;
        int         a0;
        logic [1:0] o2;
        cur = name;
        q.delete();
        a0 = n_ack;
        @(negedge clk);
        bus.miss_req  = 1'b1;
        bus.miss_addr = a;
        t = cyc;
        @(negedge clk);
        chk("mem_req_hi", bus.mem_req, 64'd1);
        chk("mem_addr", bus.mem_addr, a);
        repeat (gdly) @(negedge clk);
        bus.mem_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rerr   = 1'b0;
            bus.flush_req  = 1'b0;
            if (k == 0) chk("mem_req_lo", bus.mem_req, 64'd0);
            if (k == 3) repeat (gap3) @(negedge clk);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'(32'hA0 + k);
            bus.mem_rerr   = emask[k];
            if (k == flush_k) bus.flush_req = 1'b1;
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rerr   = 1'b0;
        bus.flush_req  = 1'b0;
        if (!keep_req) bus.miss_req = 1'b0;
        #1;
        chk("ack_count", n_ack - a0, 64'd1);
        chk("ack_cycle", ack_cyc, t + 6 + gdly + gap3);
        chk("ack_err", ack_err, |emask);
        chk("n_writes", q.size(), 64'd4);
        for (int k = 0; k < 4 && k < q.size(); k++) begin
            o2   = a[1:0] + 2'(k);
            bcyc = t + 2 + gdly + k + ((k == 3) ? gap3 : 0);
            chk("wr_cycle", q[k].c, bcyc + 1);
            chk("wr_index", q[k].idx, {a[9:2], o2});
            chk("wr_data", q[k].d, 32'hA0 + k);
            chk("wr_tag", q[k].tag, a[26:10]);
            chk("wr_flags", q[k].fl, {emask[k], ~emask[k]});
            chk("wr_req_data", q[k].rd, 64'd1);
        end
    endtask

    // Wait (bounded) for flush_done and check the whole sweep.
    task automatic wait_flush(input string name, input int first_cyc);
        int fd0;
        int nbad;
        bit seen_req;
        cur = name;
        fd0 = n_fd;
        nbad = 0;
        seen_req = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            #1;
            if (bus.mem_req) seen_req = 1'b1;
            if (n_fd != fd0) break;
        end
        chk("flush_done_seen", n_fd - fd0, 64'd1);
        chk("flush_done_cycle", fd_cyc, first_cyc + 1023);
        chk("no_mem_req_in_flush", seen_req, 64'd0);
        chk("flush_writes", q.size(), 64'd1024);
        if (q.size() > 0) chk("flush_first_cycle", q[0].c, first_cyc);
        foreach (q[i]) begin
            if (q[i].idx != 10'(i) || q[i].fl != 2'b00 || q[i].rd || q[i].tag != 17'd0 ||
                q[i].c != first_cyc + i) nbad++;
        end
        chk("flush_bad_writes", nbad, 64'd0);
    endtask

    initial begin
        int t;
        int ackc;
        int a0;
        bus.miss_req   = 1'b0;
        bus.miss_addr  = '0;
        bus.flush_req  = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_rerr   = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        cur = "reset";
        chk_outs_zero();
        rst = 1'b0;
        @(negedge clk);
        chk("busy_after_reset", bus.busy, 64'd0);

        // Aligned line at byte 0x1230: indices 0x08C..0x08F, tag 1.
        run_miss("aligned", 27'h48C, 0, 0, 4'b0000, -1, 1'b0);
        // Critical word at offset 3: 0x08F, 0x08C, 0x08D, 0x08E.
        run_miss("wrap", 27'h48F, 0, 0, 4'b0000, -1, 1'b0);
        // Beat 1 errors: flags 10 on that word, miss_err set.
        run_miss("err_beat", 27'h48C, 0, 0, 4'b0010, -1, 1'b0);
        // 3-cycle grant stall plus 2-cycle gap before beat 3: ack at t+11.
        run_miss("stalls", 27'h48E, 3, 2, 4'b0000, -1, 1'b0);

        // Flush during FILL, with the next miss held through the sweep.
        run_miss("collision", 27'h48C, 0, 0, 4'b0000, 1, 1'b1);
        cur = "collision";
        chk("busy_pending", bus.busy, 64'd1);
        ackc = ack_cyc;
        q.delete();
        bus.miss_addr = 27'h48F;
        wait_flush("collision_flush", ackc + 1);
        run_miss("held_miss", 27'h48F, 0, 0, 4'b0000, -1, 1'b0);

        // Flush and miss in the same IDLE cycle: flush first.
        cur = "flush_and_miss";
        q.delete();
        @(negedge clk);
        bus.flush_req = 1'b1;
        bus.miss_req  = 1'b1;
        bus.miss_addr = 27'h48D;
        t = cyc;
        @(negedge clk);
        bus.flush_req = 1'b0;
        wait_flush("flush_first", t + 1);
        run_miss("miss_after_flush", 27'h48D, 0, 0, 4'b0000, -1, 1'b0);

        // Reset after two beats; later beats must be ignored.
        cur = "reset_mid_fill";
        q.delete();
        a0 = n_ack;
        @(negedge clk);
        bus.miss_req  = 1'b1;
        bus.miss_addr = 27'h48C;
        @(negedge clk);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hA0;
        @(negedge clk);
        bus.mem_rdata  = 32'hA1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_outs_zero();
        chk("writes_before_reset", q.size(), 64'd2);
        @(negedge clk);
        bus.miss_req   = 1'b0;
        rst            = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hA2;
        @(negedge clk);
        bus.mem_rdata  = 32'hA3;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("writes_after_reset", q.size(), 64'd2);
        chk("no_ack_after_reset", n_ack - a0, 64'd0);
        chk_outs_zero();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
